// File: rtl/fbp_angle_group_scheduler.sv
// Frame-level sequencer: one angle-data transaction per frame, one back-projection launch per angle group.
// Optional per-wait-state watchdog, enabled by defining FBP_SCHED_TIMEOUT_EN.
module fbp_angle_group_scheduler #(
   parameter int unsigned ANGLE_NUM      = 180,
   parameter int unsigned ANGLE_STEP     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       arstn,
   input  logic       frame_start,
   input  logic       frame_abort,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] group_idx,
   output logic       sched_err,
   output logic       sched_timeout,
   output logic       ctl_start_txn,
   output logic       ctl_get_next,
   input  logic [7:0] ctl_angle_num,
   input  logic       ctl_angle_num_valid,
   input  logic       ctl_all_done,
   output logic       bp_start,
   output logic [7:0] bp_angle,
   input  logic       bp_done
);

   localparam int unsigned GROUP_NUM = ANGLE_NUM / ANGLE_STEP;
   localparam int unsigned IDX_W     = 8;
   localparam int unsigned ANG_W     = 8;
   localparam logic [IDX_W-1:0] LAST_GRP = IDX_W'(GROUP_NUM - 1);
   localparam logic [ANG_W-1:0] STEP_A   = ANG_W'(ANGLE_STEP);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_BSTART = 3'd2;
   localparam logic [2:0] S_BP_RUN = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]       state_q, state_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic [IDX_W-1:0] group_idx_q, group_idx_d;
   logic             sched_err_q, sched_err_d;
   logic             ctl_start_txn_q, ctl_start_txn_d;
   logic             ctl_get_next_q, ctl_get_next_d;
   logic             bp_start_q, bp_start_d;
   logic [ANG_W-1:0] bp_angle_q, bp_angle_d;
   logic [ANG_W-1:0] exp_angle_c;
   logic             timeout_hit_c;

   // Angle the controller should deliver for the current group
   assign exp_angle_c = ANG_W'(group_idx_q * STEP_A);

   always_comb begin
      state_d         = state_q;
      busy_d          = busy_q;
      frame_done_d    = 1'b0;
      group_idx_d     = group_idx_q;
      sched_err_d     = sched_err_q;
      ctl_start_txn_d = 1'b0;
      ctl_get_next_d  = 1'b0;
      bp_start_d      = 1'b0;
      bp_angle_d      = bp_angle_q;

      if (frame_abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         busy_d      = 1'b0;
         group_idx_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (frame_start && !frame_abort) begin
                  state_d         = S_LOAD;
                  busy_d          = 1'b1;
                  group_idx_d     = '0;
                  sched_err_d     = 1'b0;
                  ctl_start_txn_d = 1'b1;
               end
            end
            S_LOAD: begin
               if (ctl_angle_num_valid) begin
                  bp_angle_d = ctl_angle_num;
                  state_d    = S_BSTART;
                  if (ctl_angle_num != exp_angle_c) sched_err_d = 1'b1;
               end else if (timeout_hit_c) begin
                  state_d     = S_IDLE;
                  busy_d      = 1'b0;
                  group_idx_d = '0;
                  sched_err_d = 1'b1;
               end
            end
            S_BSTART: begin
               bp_start_d = 1'b1;
               state_d    = S_BP_RUN;
            end
            S_BP_RUN: begin
               if (bp_done) begin
                  if (group_idx_q == LAST_GRP) begin
                     state_d = S_DRAIN;
                  end else begin
                     group_idx_d    = group_idx_q + IDX_W'(1);
                     ctl_get_next_d = 1'b1;
                     state_d        = S_LOAD;
                  end
               end else if (timeout_hit_c) begin
                  state_d     = S_IDLE;
                  busy_d      = 1'b0;
                  group_idx_d = '0;
                  sched_err_d = 1'b1;
               end
            end
            S_DRAIN: begin
               if (ctl_all_done) begin
                  state_d = S_DONE;
               end else if (timeout_hit_c) begin
                  state_d     = S_IDLE;
                  busy_d      = 1'b0;
                  group_idx_d = '0;
                  sched_err_d = 1'b1;
               end
            end
            S_DONE: begin
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = S_IDLE;
            end
            default: begin
               state_d     = S_IDLE;
               busy_d      = 1'b0;
               group_idx_d = '0;
            end
         endcase
      end

      // Handshakes arriving in the wrong state are dropped but flagged
      if (bp_done && (state_q != S_BP_RUN)) sched_err_d = 1'b1;
      if (ctl_angle_num_valid && (state_q != S_LOAD)) sched_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q         <= S_IDLE;
         busy_q          <= 1'b0;
         frame_done_q    <= 1'b0;
         group_idx_q     <= '0;
         sched_err_q     <= 1'b0;
         ctl_start_txn_q <= 1'b0;
         ctl_get_next_q  <= 1'b0;
         bp_start_q      <= 1'b0;
         bp_angle_q      <= '0;
      end else begin
         state_q         <= state_d;
         busy_q          <= busy_d;
         frame_done_q    <= frame_done_d;
         group_idx_q     <= group_idx_d;
         sched_err_q     <= sched_err_d;
         ctl_start_txn_q <= ctl_start_txn_d;
         ctl_get_next_q  <= ctl_get_next_d;
         bp_start_q      <= bp_start_d;
         bp_angle_q      <= bp_angle_d;
      end
   end

`ifdef FBP_SCHED_TIMEOUT_EN
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             wait_state_c;
   logic             sched_timeout_q, sched_timeout_d;

   assign wait_state_c  = (state_q == S_LOAD) || (state_q == S_BP_RUN) || (state_q == S_DRAIN);
   assign timeout_hit_c = wait_state_c && (wd_cnt_q == TO_LAST);

   // Only the watchdog can move a wait state to IDLE without an abort
   always_comb begin
      wd_cnt_d        = wd_cnt_q;
      sched_timeout_d = timeout_hit_c && !frame_abort && (state_d == S_IDLE);
      if (state_d != state_q) begin
         wd_cnt_d = '0;
      end else if (wait_state_c) begin
         wd_cnt_d = wd_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wd_cnt_q        <= '0;
         sched_timeout_q <= 1'b0;
      end else begin
         wd_cnt_q        <= wd_cnt_d;
         sched_timeout_q <= sched_timeout_d;
      end
   end

   assign sched_timeout = sched_timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
   assign timeout_hit_c      = 1'b0;
   assign sched_timeout      = 1'b0;
`endif

   assign busy          = busy_q;
   assign frame_done    = frame_done_q;
   assign group_idx     = group_idx_q;
   assign sched_err     = sched_err_q;
   assign ctl_start_txn = ctl_start_txn_q;
   assign ctl_get_next  = ctl_get_next_q;
   assign bp_start      = bp_start_q;
   assign bp_angle      = bp_angle_q;

endmodule

// File: tb/tb_fbp_angle_group_scheduler.sv
// Directed bench for fbp_angle_group_scheduler; watchdog scenario depends on FBP_SCHED_TIMEOUT_EN.
module tb_fbp_angle_group_scheduler;

   localparam int unsigned GROUP_NUM  = 18;
   localparam int unsigned ANGLE_STEP = 10;

   logic       clk = 1'b0;
   logic       arstn = 1'b0;
   logic       frame_start = 1'b0;
   logic       frame_abort = 1'b0;
   logic [7:0] ctl_angle_num = '0;
   logic       ctl_angle_num_valid = 1'b0;
   logic       ctl_all_done = 1'b0;
   logic       bp_done = 1'b0;
   logic       busy, frame_done, sched_err, sched_timeout;
   logic       ctl_start_txn, ctl_get_next, bp_start;
   logic [7:0] group_idx, bp_angle;

   int n_tests = 0;
   int n_fail  = 0;
   int n_bp_start = 0;
   int n_get_next = 0;
   int n_frame_done = 0;
   int n_start_txn = 0;

   always #5 clk = ~clk;

   fbp_angle_group_scheduler #(
      .ANGLE_NUM     (180),
      .ANGLE_STEP    (10),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk                (clk),
      .arstn              (arstn),
      .frame_start        (frame_start),
      .frame_abort        (frame_abort),
      .busy               (busy),
      .frame_done         (frame_done),
      .group_idx          (group_idx),
      .sched_err          (sched_err),
      .sched_timeout      (sched_timeout),
      .ctl_start_txn      (ctl_start_txn),
      .ctl_get_next       (ctl_get_next),
      .ctl_angle_num      (ctl_angle_num),
      .ctl_angle_num_valid(ctl_angle_num_valid),
      .ctl_all_done       (ctl_all_done),
      .bp_start           (bp_start),
      .bp_angle           (bp_angle),
      .bp_done            (bp_done)
   );

   // Pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (bp_start === 1'b1)      n_bp_start   <= n_bp_start + 1;
      if (ctl_get_next === 1'b1)  n_get_next   <= n_get_next + 1;
      if (frame_done === 1'b1)    n_frame_done <= n_frame_done + 1;
      if (ctl_start_txn === 1'b1) n_start_txn  <= n_start_txn + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drives one frame as the angle controller and pipelines; stops in BP_RUN of stop_grp if >= 0
   task automatic run_frame(input int bad_grp, input logic [7:0] bad_ang, input int stop_grp);
      logic [7:0] ang;
      logic       err_exp;
      err_exp = 1'b0;
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      n_tests++;
      if ({ctl_start_txn, busy, group_idx} !== {1'b1, 1'b1, 8'd0}) begin
         n_fail++;
         $display("FAIL frame_accept: got start_txn=%0b busy=%0b grp=%0d want 1 1 0", ctl_start_txn, busy, group_idx);
      end
      for (int g = 0; g < int'(GROUP_NUM); g++) begin
         ang = (g == bad_grp) ? bad_ang : 8'(g * ANGLE_STEP);
         if (g == bad_grp) err_exp = 1'b1;
         cyc();
         cyc();
         ctl_angle_num = ang;
         ctl_angle_num_valid = 1'b1;
         cyc();
         ctl_angle_num_valid = 1'b0;
         n_tests++;
         if (bp_start !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_start_early g=%0d: got %0b want 0", g, bp_start);
         end
         cyc();
         n_tests++;
         if ({bp_start, bp_angle, group_idx, sched_err} !== {1'b1, ang, 8'(g), err_exp}) begin
            n_fail++;
            $display("FAIL bp_launch g=%0d: got start=%0b ang=%0d grp=%0d err=%0b want 1 %0d %0d %0b",
                     g, bp_start, bp_angle, group_idx, sched_err, ang, g, err_exp);
         end
         if (g == stop_grp) return;
         repeat (19) cyc();
         bp_done = 1'b1;
         cyc();
         bp_done = 1'b0;
         n_tests++;
         if (g < int'(GROUP_NUM) - 1) begin
            if ({ctl_get_next, group_idx} !== {1'b1, 8'(g + 1)}) begin
               n_fail++;
               $display("FAIL get_next g=%0d: got gn=%0b grp=%0d want 1 %0d", g, ctl_get_next, group_idx, g + 1);
            end
         end else if ({ctl_get_next, busy, group_idx} !== {1'b0, 1'b1, 8'(GROUP_NUM - 1)}) begin
            n_fail++;
            $display("FAIL last_group: got gn=%0b busy=%0b grp=%0d want 0 1 %0d",
                     ctl_get_next, busy, group_idx, GROUP_NUM - 1);
         end
      end
      cyc();
      ctl_all_done = 1'b1;
      cyc();
      n_tests++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_done_early: got %0b want 0", frame_done);
      end
      cyc();
      ctl_all_done = 1'b0;
      n_tests++;
      if ({frame_done, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL frame_done: got done=%0b busy=%0b want 1 0", frame_done, busy);
      end
      cyc();
      n_tests++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_done_width: got %0b want 0", frame_done);
      end
   endtask

   task automatic test_reset();
      arstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, frame_done, group_idx, sched_err, sched_timeout, ctl_start_txn, ctl_get_next, bp_start, bp_angle}
          !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%0b grp=%0d err=%0b ang=%0d want all 0", busy, group_idx, sched_err, bp_angle);
      end
      @(negedge clk);
      arstn = 1'b1;
      cyc();
      cyc();
      n_tests++;
      if ({busy, ctl_start_txn, frame_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%0b txn=%0b done=%0b want 0 0 0", busy, ctl_start_txn, frame_done);
      end
   endtask

   task automatic test_nominal();
      int bs0, gn0, fd0, st0;
      bs0 = n_bp_start; gn0 = n_get_next; fd0 = n_frame_done; st0 = n_start_txn;
      run_frame(-1, 8'd0, -1);
      cyc();
      n_tests++;
      if ((n_bp_start - bs0) != 18 || (n_get_next - gn0) != 17 || (n_frame_done - fd0) != 1 || (n_start_txn - st0) != 1) begin
         n_fail++;
         $display("FAIL nominal_counts: got bp=%0d gn=%0d fd=%0d txn=%0d want 18 17 1 1",
                  n_bp_start - bs0, n_get_next - gn0, n_frame_done - fd0, n_start_txn - st0);
      end
      n_tests++;
      if (sched_err !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_err: got %0b want 0", sched_err);
      end
   endtask

   task automatic test_angle_mismatch();
      int fd0;
      fd0 = n_frame_done;
      run_frame(1, 8'd20, -1);
      cyc();
      n_tests++;
      if (sched_err !== 1'b1 || (n_frame_done - fd0) != 1) begin
         n_fail++;
         $display("FAIL mismatch: got err=%0b frames=%0d want 1 1", sched_err, n_frame_done - fd0);
      end
   endtask

   task automatic test_abort();
      int fd0;
      fd0 = n_frame_done;
      run_frame(-1, 8'd0, 5);
      repeat (3) cyc();
      frame_abort = 1'b1;
      cyc();
      frame_abort = 1'b0;
      n_tests++;
      if ({busy, group_idx, sched_err} !== {1'b0, 8'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL abort_state: got busy=%0b grp=%0d err=%0b want 0 0 0", busy, group_idx, sched_err);
      end
      repeat (30) cyc();
      n_tests++;
      if (n_frame_done != fd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: got frames=%0d busy=%0b want 0 0", n_frame_done - fd0, busy);
      end
      run_frame(-1, 8'd0, -1);
   endtask

   task automatic test_stray_inputs();
      run_frame(-1, 8'd0, 3);
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      n_tests++;
      if ({busy, group_idx, ctl_start_txn, sched_err} !== {1'b1, 8'd3, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL start_while_busy: got busy=%0b grp=%0d txn=%0b err=%0b want 1 3 0 0",
                  busy, group_idx, ctl_start_txn, sched_err);
      end
      bp_done = 1'b1;
      cyc();
      bp_done = 1'b0;
      bp_done = 1'b1;
      cyc();
      bp_done = 1'b0;
      n_tests++;
      if ({sched_err, group_idx, bp_start, ctl_get_next, busy} !== {1'b1, 8'd4, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL bp_done_in_load: got err=%0b grp=%0d bs=%0b gn=%0b busy=%0b want 1 4 0 0 1",
                  sched_err, group_idx, bp_start, ctl_get_next, busy);
      end
      ctl_angle_num = 8'd40;
      ctl_angle_num_valid = 1'b1;
      cyc();
      ctl_angle_num_valid = 1'b0;
      cyc();
      n_tests++;
      if ({bp_start, bp_angle} !== {1'b1, 8'd40}) begin
         n_fail++;
         $display("FAIL load_after_stray: got bs=%0b ang=%0d want 1 40", bp_start, bp_angle);
      end
      bp_done = 1'b1;
      ctl_angle_num = 8'd99;
      ctl_angle_num_valid = 1'b1;
      cyc();
      bp_done = 1'b0;
      ctl_angle_num_valid = 1'b0;
      n_tests++;
      if ({ctl_get_next, group_idx, bp_angle} !== {1'b1, 8'd5, 8'd40}) begin
         n_fail++;
         $display("FAIL done_plus_valid: got gn=%0b grp=%0d ang=%0d want 1 5 40", ctl_get_next, group_idx, bp_angle);
      end
      frame_abort = 1'b1;
      cyc();
      frame_abort = 1'b0;
      n_tests++;
      if ({busy, sched_err} !== 2'b01) begin
         n_fail++;
         $display("FAIL abort_holds_err: got busy=%0b err=%0b want 0 1", busy, sched_err);
      end
      frame_start = 1'b1;
      frame_abort = 1'b1;
      cyc();
      frame_start = 1'b0;
      frame_abort = 1'b0;
      cyc();
      n_tests++;
      if ({busy, ctl_start_txn, group_idx} !== {1'b0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL start_abort_idle: got busy=%0b txn=%0b grp=%0d want 0 0 0", busy, ctl_start_txn, group_idx);
      end
   endtask

   task automatic test_async_reset();
      run_frame(-1, 8'd0, 2);
      repeat (5) cyc();
      bp_done = 1'b1;
      cyc();
      bp_done = 1'b0;
      n_tests++;
      if ({ctl_get_next, group_idx} !== {1'b1, 8'd3}) begin
         n_fail++;
         $display("FAIL pre_reset_load: got gn=%0b grp=%0d want 1 3", ctl_get_next, group_idx);
      end
      #2;
      arstn = 1'b0;
      #1;
      n_tests++;
      if ({busy, frame_done, group_idx, sched_err, ctl_start_txn, ctl_get_next, bp_start, bp_angle} !== 22'd0) begin
         n_fail++;
         $display("FAIL async_reset: got busy=%0b grp=%0d gn=%0b ang=%0d want all 0", busy, group_idx, ctl_get_next, bp_angle);
      end
      @(negedge clk);
      arstn = 1'b1;
      cyc();
      run_frame(-1, 8'd0, -1);
   endtask

   task automatic test_watchdog();
      int seen_at;
      int fd0;
      seen_at = -1;
      fd0 = n_frame_done;
      run_frame(-1, 8'd0, 0);
`ifdef FBP_SCHED_TIMEOUT_EN
      for (int i = 1; i <= 200; i++) begin
         cyc();
         if (sched_timeout === 1'b1) begin
            seen_at = i;
            break;
         end
      end
      n_tests++;
      if (seen_at != 100) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d want 100", seen_at);
      end
      n_tests++;
      if ({busy, sched_err, group_idx} !== {1'b0, 1'b1, 8'd0} || n_frame_done != fd0) begin
         n_fail++;
         $display("FAIL timeout_state: got busy=%0b err=%0b grp=%0d frames=%0d want 0 1 0 0",
                  busy, sched_err, group_idx, n_frame_done - fd0);
      end
      cyc();
      n_tests++;
      if (sched_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_width: got %0b want 0", sched_timeout);
      end
`else
      repeat (1000) cyc();
      n_tests++;
      if ({busy, group_idx, sched_timeout, sched_err} !== {1'b1, 8'd0, 1'b0, 1'b0} || n_frame_done != fd0) begin
         n_fail++;
         $display("FAIL no_watchdog: got busy=%0b grp=%0d to=%0b err=%0b want 1 0 0 0",
                  busy, group_idx, sched_timeout, sched_err);
      end
      frame_abort = 1'b1;
      cyc();
      frame_abort = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_watchdog_abort: got busy=%0b want 0", busy);
      end
      if (seen_at != -1) n_fail++;
`endif
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_angle_mismatch();
      test_abort();
      test_stray_inputs();
      test_async_reset();
      test_watchdog();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
